// File: rtl/branch_resolve_if.sv
// Issue/resolve bundle between the issue stage, the resolver and the PC/predictor.
// The master drives instruction issue; the slave (resolver) returns redirects and statistics.
interface branch_resolve_if #(
    parameter int CNT_W = 16
);
    logic              br_valid_i;
    logic [31:0]       br_pc_i;
    logic [31:0]       br_inst_i;
    logic              br_pred_i;
    logic [31:0]       rs1_i;
    logic [31:0]       rs2_i;
    logic [2:0]        jump_cause_o;
    logic [31:0]       jump_from_addr_o;
    logic [31:0]       jump_to_addr_o;
    logic [CNT_W-1:0]  branch_cnt_o;
    logic [CNT_W-1:0]  mispred_cnt_o;

    modport master (
        output br_valid_i, br_pc_i, br_inst_i, br_pred_i, rs1_i, rs2_i,
        input  jump_cause_o, jump_from_addr_o, jump_to_addr_o, branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  br_valid_i, br_pc_i, br_inst_i, br_pred_i, rs1_i, rs2_i,
        output jump_cause_o, jump_from_addr_o, jump_to_addr_o, branch_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: captures issued control-flow instructions, computes the
// real outcome against the predictor's guess, pulses a registered redirect to the PC,
// squashes wrong-path issues behind a redirect and keeps saturating statistics.
module branch_resolve #(
    parameter int          SHADOW   = 1,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold_i,
    input  logic            flush_i,
    branch_resolve_if.slave bus
);

    localparam logic [6:0]       OP_BRANCH   = 7'b1100011;
    localparam logic [6:0]       OP_JAL      = 7'b1101111;
    localparam logic [6:0]       OP_JALR     = 7'b1100111;
    localparam logic [1:0]       SHADOW_INIT = 2'(SHADOW);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        CAUSE_NONE        = 3'd0,
        CAUSE_PRED_NO_BUT = 3'd1,
        CAUSE_PRED_YES_BUT= 3'd2,
        CAUSE_UNCOND      = 3'd3,
        CAUSE_EXCEPTION   = 3'd5
    } cause_e;

    logic              stage_valid_q, stage_valid_d;
    logic [31:0]       stage_pc_q,    stage_pc_d;
    logic [31:0]       stage_inst_q,  stage_inst_d;
    logic              stage_pred_q,  stage_pred_d;
    logic [31:0]       stage_rs1_q,   stage_rs1_d;
    logic [31:0]       stage_rs2_q,   stage_rs2_d;
    logic [1:0]        shadow_q,      shadow_d;
    cause_e            cause_q,       cause_d;
    logic [31:0]       from_q,        from_d;
    logic [31:0]       to_q,          to_d;
    logic [CNT_W-1:0]  branch_cnt_q,  branch_cnt_d;
    logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_i;
    logic        issue_is_cf;
    logic        resolve;
    logic        taken;
    cause_e      res_cause;
    logic [31:0] res_to;
    logic        res_cond;

    assign opcode = stage_inst_q[6:0];
    assign funct3 = stage_inst_q[14:12];
    assign imm_b  = {{19{stage_inst_q[31]}}, stage_inst_q[31], stage_inst_q[7],
                     stage_inst_q[30:25], stage_inst_q[11:8], 1'b0};
    assign imm_j  = {{11{stage_inst_q[31]}}, stage_inst_q[31], stage_inst_q[19:12],
                     stage_inst_q[20], stage_inst_q[30:21], 1'b0};
    assign imm_i  = {{20{stage_inst_q[31]}}, stage_inst_q[31:20]};

    assign issue_is_cf = (bus.br_inst_i[6:0] == OP_BRANCH) ||
                         (bus.br_inst_i[6:0] == OP_JAL)    ||
                         (bus.br_inst_i[6:0] == OP_JALR);
    assign resolve = stage_valid_q & ~hold_i & ~flush_i;

    // Evaluate the staged instruction: real direction, redirect cause and correct next pc.
    always_comb begin
        taken     = 1'b0;
        res_cause = CAUSE_NONE;
        res_to    = stage_pc_q + 32'd4;
        res_cond  = 1'b0;
        case (opcode)
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  taken = (stage_rs1_q == stage_rs2_q);
                    3'b001:  taken = (stage_rs1_q != stage_rs2_q);
                    3'b100:  taken = ($signed(stage_rs1_q) <  $signed(stage_rs2_q));
                    3'b101:  taken = ($signed(stage_rs1_q) >= $signed(stage_rs2_q));
                    3'b110:  taken = (stage_rs1_q <  stage_rs2_q);
                    3'b111:  taken = (stage_rs1_q >= stage_rs2_q);
                    default: taken = 1'b0;
                endcase
                if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
                    res_cause = CAUSE_EXCEPTION;
                    res_to    = TRAP_VEC;
                end else begin
                    res_cond = 1'b1;
                    if (taken && !stage_pred_q) begin
                        res_cause = CAUSE_PRED_NO_BUT;
                        res_to    = stage_pc_q + imm_b;
                    end else if (!taken && stage_pred_q) begin
                        res_cause = CAUSE_PRED_YES_BUT;
                        res_to    = stage_pc_q + 32'd4;
                    end
                end
            end
            OP_JAL: begin
                res_cause = CAUSE_UNCOND;
                res_to    = stage_pc_q + imm_j;
            end
            OP_JALR: begin
                res_cause = CAUSE_UNCOND;
                res_to    = (stage_rs1_q + imm_i) & ~32'd1;
            end
            default: begin
                res_cause = CAUSE_NONE;
            end
        endcase
    end

    // Next-state for the stage register, shadow window, redirect outputs and counters.
    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_pc_d    = stage_pc_q;
        stage_inst_d  = stage_inst_q;
        stage_pred_d  = stage_pred_q;
        stage_rs1_d   = stage_rs1_q;
        stage_rs2_d   = stage_rs2_q;
        shadow_d      = shadow_q;
        cause_d       = CAUSE_NONE;
        from_d        = from_q;
        to_d          = to_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (flush_i) begin
            stage_valid_d = 1'b0;
        end else if (!hold_i) begin
            if (bus.br_valid_i && (shadow_q == 2'd0) && issue_is_cf) begin
                stage_valid_d = 1'b1;
                stage_pc_d    = bus.br_pc_i;
                stage_inst_d  = bus.br_inst_i;
                stage_pred_d  = bus.br_pred_i;
                stage_rs1_d   = bus.rs1_i;
                stage_rs2_d   = bus.rs2_i;
            end else begin
                stage_valid_d = 1'b0;
            end
        end

        if (resolve) begin
            cause_d = res_cause;
            if (res_cause != CAUSE_NONE) begin
                from_d = stage_pc_q;
                to_d   = res_to;
            end
            if (res_cond && (branch_cnt_q != {CNT_W{1'b1}})) begin
                branch_cnt_d = branch_cnt_q + CNT_ONE;
            end
            if (((res_cause == CAUSE_PRED_NO_BUT) || (res_cause == CAUSE_PRED_YES_BUT)) &&
                (mispred_cnt_q != {CNT_W{1'b1}})) begin
                mispred_cnt_d = mispred_cnt_q + CNT_ONE;
            end
        end

        if (flush_i) begin
            shadow_d = 2'd0;
        end else if (resolve && (res_cause != CAUSE_NONE)) begin
            shadow_d = SHADOW_INIT;
        end else if (!hold_i && (shadow_q != 2'd0)) begin
            shadow_d = shadow_q - 2'd1;
        end
    end

    // State and output registers; reset clears every output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_q <= 1'b0;
            stage_pc_q    <= 32'd0;
            stage_inst_q  <= 32'd0;
            stage_pred_q  <= 1'b0;
            stage_rs1_q   <= 32'd0;
            stage_rs2_q   <= 32'd0;
            shadow_q      <= 2'd0;
            cause_q       <= CAUSE_NONE;
            from_q        <= 32'd0;
            to_q          <= 32'd0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_pc_q    <= stage_pc_d;
            stage_inst_q  <= stage_inst_d;
            stage_pred_q  <= stage_pred_d;
            stage_rs1_q   <= stage_rs1_d;
            stage_rs2_q   <= stage_rs2_d;
            shadow_q      <= shadow_d;
            cause_q       <= cause_d;
            from_q        <= from_d;
            to_q          <= to_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.jump_cause_o     = cause_q;
    assign bus.jump_from_addr_o = from_q;
    assign bus.jump_to_addr_o   = to_q;
    assign bus.branch_cnt_o     = branch_cnt_q;
    assign bus.mispred_cnt_o    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized traffic,
// all compared against a behavioural reference model of the resolver.
module tb_branch_resolve;

    localparam int          SHADOW  = 1;
    localparam int          CNT_W   = 4;
    localparam logic [31:0] TRAP    = 32'h0000_0100;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic hold;
    logic flush;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state: staged instruction, shadow window, expected outputs.
    bit          mValid;
    logic [31:0] mPc, mInst, mRs1, mRs2;
    bit          mPred;
    int          mShadow;
    int          expCause;
    logic [31:0] expFrom, expTo;
    int          expBranchCnt, expMispredCnt;

    branch_resolve_if #(.CNT_W(CNT_W)) bus ();

    branch_resolve #(
        .SHADOW   (SHADOW),
        .CNT_W    (CNT_W),
        .TRAP_VEC (TRAP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (hold),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [31:0] pc, input logic [31:0] inst,
                                 input bit pred, input logic [31:0] a, input logic [31:0] b);
        bus.br_valid_i = valid;
        bus.br_pc_i    = pc;
        bus.br_inst_i  = inst;
        bus.br_pred_i  = pred;
        bus.rs1_i      = a;
        bus.rs2_i      = b;
    endtask

    function automatic longint fld(input logic [31:0] v, input int lo, input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return longint'((v >> lo) & mask);
    endfunction

    function automatic bit isControlFlow(input logic [31:0] inst);
        longint opc;
        opc = fld(inst, 0, 7);
        return (opc == 'h63) || (opc == 'h6f) || (opc == 'h67);
    endfunction

    // Architectural outcome of one control-flow instruction from its decoded fields.
    task automatic refResolve(input logic [31:0] pc, input logic [31:0] inst, input bit pred,
                              input logic [31:0] a, input logic [31:0] b,
                              output int cause, output logic [31:0] to, output bit cond);
        longint opc, f3, off;
        bit taken;
        logic [31:0] t;
        opc   = fld(inst, 0, 7);
        f3    = fld(inst, 12, 3);
        cause = 0;
        cond  = 1'b0;
        taken = 1'b0;
        to    = pc + 32'd4;
        if (opc == 'h63) begin
            if (f3 == 2 || f3 == 3) begin
                cause = 5;
                to    = TRAP;
            end else begin
                off = fld(inst, 8, 4) * 2 + fld(inst, 25, 6) * 32 + fld(inst, 7, 1) * 2048
                      - fld(inst, 31, 1) * 4096;
                case (f3)
                    0: taken = (a == b);
                    1: taken = (a != b);
                    4: taken = (int'(a) < int'(b));
                    5: taken = (int'(a) >= int'(b));
                    6: taken = (a < b);
                    default: taken = (a >= b);
                endcase
                cond = 1'b1;
                if (taken && !pred) begin
                    cause = 1;
                    to    = 32'(longint'(pc) + off);
                end else if (!taken && pred) begin
                    cause = 2;
                end
            end
        end else if (opc == 'h6f) begin
            off   = fld(inst, 21, 10) * 2 + fld(inst, 20, 1) * 2048 + fld(inst, 12, 8) * 4096
                    - fld(inst, 31, 1) * 1048576;
            cause = 3;
            to    = 32'(longint'(pc) + off);
        end else if (opc == 'h67) begin
            off   = fld(inst, 20, 11) - fld(inst, 31, 1) * 2048;
            t     = 32'(longint'(a) + off);
            cause = 3;
            to    = t - (t % 2);
        end
    endtask

    task automatic modelReset();
        mValid        = 1'b0;
        mShadow       = 0;
        expCause      = 0;
        expFrom       = 32'd0;
        expTo         = 32'd0;
        expBranchCnt  = 0;
        expMispredCnt = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelEdge();
        int cause;
        logic [31:0] to;
        bit cond;
        bit resolving;
        int oldShadow;
        cause     = 0;
        to        = 32'd0;
        cond      = 1'b0;
        resolving = mValid && !hold && !flush;
        oldShadow = mShadow;
        expCause  = 0;
        if (resolving) begin
            refResolve(mPc, mInst, mPred, mRs1, mRs2, cause, to, cond);
            expCause = cause;
            if (cause != 0) begin
                expFrom = mPc;
                expTo   = to;
            end
            if (cond && expBranchCnt < CNT_MAX) expBranchCnt++;
            if ((cause == 1 || cause == 2) && expMispredCnt < CNT_MAX) expMispredCnt++;
        end
        if (flush) mShadow = 0;
        else if (resolving && cause != 0) mShadow = SHADOW;
        else if (!hold && mShadow > 0) mShadow--;
        if (flush) begin
            mValid = 1'b0;
        end else if (!hold) begin
            if (bus.br_valid_i && oldShadow == 0 && isControlFlow(bus.br_inst_i)) begin
                mValid = 1'b1;
                mPc    = bus.br_pc_i;
                mInst  = bus.br_inst_i;
                mPred  = bus.br_pred_i;
                mRs1   = bus.rs1_i;
                mRs2   = bus.rs2_i;
            end else begin
                mValid = 1'b0;
            end
        end
    endtask

    task automatic stepCycle();
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("cause",   32'(bus.jump_cause_o),  32'(expCause));
        checkOutput("from",    bus.jump_from_addr_o,   expFrom);
        checkOutput("to",      bus.jump_to_addr_o,     expTo);
        checkOutput("brcnt",   32'(bus.branch_cnt_o),  32'(expBranchCnt));
        checkOutput("miscnt",  32'(bus.mispred_cnt_o), 32'(expMispredCnt));
    endtask

    task automatic idle(input int n);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        repeat (n) stepCycle();
    endtask

    // Issue one instruction and stop on the cycle its redirect pulse is visible.
    task automatic issueAndResolve(input logic [31:0] pc, input logic [31:0] inst, input bit pred,
                                   input logic [31:0] a, input logic [31:0] b);
        applyStimulus(1'b1, pc, inst, pred, a, b);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        stepCycle();
    endtask

    function automatic logic [31:0] encB(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] encJalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    function automatic logic [31:0] encJal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'd5;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h8000_0000;
            5:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] genInst();
        logic [31:0] inst;
        int k;
        inst = $urandom;
        k    = $urandom_range(0, 9);
        case (k)
            0: begin inst[6:0] = 7'b1100011; inst[14:12] = 3'b000; end
            1: begin inst[6:0] = 7'b1100011; inst[14:12] = 3'b001; end
            2: begin inst[6:0] = 7'b1100011; inst[14:12] = 3'b100; end
            3: begin inst[6:0] = 7'b1100011; inst[14:12] = 3'b101; end
            4: begin inst[6:0] = 7'b1100011; inst[14:12] = 3'b110; end
            5: begin inst[6:0] = 7'b1100011; inst[14:12] = 3'b111; end
            6: begin inst[6:0] = 7'b1100011; inst[14:12] = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b011; end
            7: inst[6:0] = 7'b1101111;
            8: inst[6:0] = 7'b1100111;
            default: inst[6:0] = ($urandom_range(0, 1) == 0) ? 7'b0010011 : 7'b0110011;
        endcase
        return inst;
    endfunction

    initial begin
        logic [31:0] a;
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cause",  32'(bus.jump_cause_o),  32'd0);
        checkOutput("rst_from",   bus.jump_from_addr_o,   32'd0);
        checkOutput("rst_to",     bus.jump_to_addr_o,     32'd0);
        checkOutput("rst_brcnt",  32'(bus.branch_cnt_o),  32'd0);
        checkOutput("rst_miscnt", 32'(bus.mispred_cnt_o), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // BEQ taken but predicted not-taken: forward target redirect.
        issueAndResolve(32'h40, encB(3'b000, 13'd16), 1'b0, 32'd5, 32'd5);
        checkOutput("beq_cause", 32'(bus.jump_cause_o), 32'd1);
        checkOutput("beq_from",  bus.jump_from_addr_o,  32'h40);
        checkOutput("beq_to",    bus.jump_to_addr_o,    32'h50);
        idle(1);
        checkOutput("beq_pulse_end", 32'(bus.jump_cause_o), 32'd0);

        // BNE predicted taken but falls through; the following issue lands in the shadow.
        issueAndResolve(32'h80, encB(3'b001, 13'd8), 1'b1, 32'd7, 32'd7);
        checkOutput("bne_cause", 32'(bus.jump_cause_o), 32'd2);
        checkOutput("bne_to",    bus.jump_to_addr_o,    32'h84);
        applyStimulus(1'b1, 32'h200, encB(3'b000, 13'd16), 1'b0, 32'd1, 32'd1);
        stepCycle();
        idle(1);
        checkOutput("shadow_drop",   32'(bus.jump_cause_o),  32'd0);
        checkOutput("shadow_miscnt", 32'(bus.mispred_cnt_o), 32'd2);
        checkOutput("shadow_brcnt",  32'(bus.branch_cnt_o),  32'd2);

        // Signed versus unsigned less-than with the same operands.
        issueAndResolve(32'h100, encB(3'b100, 13'd8), 1'b1, 32'hFFFF_FFFF, 32'd1);
        checkOutput("blt_cause", 32'(bus.jump_cause_o), 32'd0);
        idle(1);
        issueAndResolve(32'h100, encB(3'b110, 13'd8), 1'b1, 32'hFFFF_FFFF, 32'd1);
        checkOutput("bltu_cause", 32'(bus.jump_cause_o), 32'd2);
        checkOutput("bltu_to",    bus.jump_to_addr_o,    32'h104);
        idle(1);

        // JALR clears bit 0 of the target and is not a conditional branch.
        issueAndResolve(32'h300, encJalr(12'd4), 1'b0, 32'h1003, 32'd0);
        checkOutput("jalr_cause", 32'(bus.jump_cause_o), 32'd3);
        checkOutput("jalr_from",  bus.jump_from_addr_o,  32'h300);
        checkOutput("jalr_to",    bus.jump_to_addr_o,    32'h1006);
        checkOutput("jalr_brcnt", 32'(bus.branch_cnt_o), 32'd4);
        idle(1);

        // JAL with a negative offset.
        issueAndResolve(32'h400, encJal(21'h1F_FFF8), 1'b1, 32'd0, 32'd0);
        checkOutput("jal_cause", 32'(bus.jump_cause_o), 32'd3);
        checkOutput("jal_to",    bus.jump_to_addr_o,    32'h3F8);
        idle(1);

        // Illegal funct3 traps and is not counted as a branch.
        issueAndResolve(32'h500, encB(3'b010, 13'd16), 1'b0, 32'd0, 32'd0);
        checkOutput("trap_cause", 32'(bus.jump_cause_o), 32'd5);
        checkOutput("trap_to",    bus.jump_to_addr_o,    TRAP);
        checkOutput("trap_brcnt", 32'(bus.branch_cnt_o), 32'd4);
        idle(1);

        // Hold freezes the staged BGE; a single pulse follows release.
        applyStimulus(1'b1, 32'h600, encB(3'b101, 13'd12), 1'b0, 32'd5, 32'd3);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        hold = 1'b1;
        repeat (3) begin
            stepCycle();
            checkOutput("hold_cause", 32'(bus.jump_cause_o), 32'd0);
        end
        hold = 1'b0;
        stepCycle();
        checkOutput("hold_release_cause", 32'(bus.jump_cause_o), 32'd1);
        checkOutput("hold_release_to",    bus.jump_to_addr_o,    32'h60C);
        idle(1);
        checkOutput("hold_single_pulse", 32'(bus.jump_cause_o), 32'd0);

        // Flush discards the staged BGE with no pulse.
        applyStimulus(1'b1, 32'h700, encB(3'b101, 13'd12), 1'b0, 32'd5, 32'd3);
        stepCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        repeat (3) begin
            stepCycle();
            checkOutput("flush_cause", 32'(bus.jump_cause_o), 32'd0);
        end

        // Twenty mispredicts saturate the 4-bit counters.
        repeat (20) begin
            issueAndResolve(32'h800, encB(3'b000, 13'd16), 1'b0, 32'd9, 32'd9);
            idle(1);
        end
        checkOutput("sat_miscnt", 32'(bus.mispred_cnt_o), 32'hF);
        checkOutput("sat_brcnt",  32'(bus.branch_cnt_o),  32'hF);

        // Randomized traffic with occasional hold and flush.
        for (int i = 0; i < 1500; i++) begin
            a = pickOperand();
            applyStimulus($urandom_range(0, 2) != 0, $urandom & 32'hFFFF_FFFC, genInst(),
                          $urandom_range(0, 1) == 1, a,
                          ($urandom_range(0, 2) == 0) ? a : pickOperand());
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            stepCycle();
        end
        hold  = 1'b0;
        flush = 1'b0;
        idle(2);

        // Asynchronous reset with an instruction staged and nonzero outputs.
        issueAndResolve(32'h900, encJal(21'd32), 1'b0, 32'd0, 32'd0);
        idle(1);
        applyStimulus(1'b1, 32'hA00, encB(3'b000, 13'd16), 1'b0, 32'd3, 32'd3);
        stepCycle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_cause",  32'(bus.jump_cause_o),  32'd0);
        checkOutput("async_from",   bus.jump_from_addr_o,   32'd0);
        checkOutput("async_to",     bus.jump_to_addr_o,     32'd0);
        checkOutput("async_brcnt",  32'(bus.branch_cnt_o),  32'd0);
        checkOutput("async_miscnt", 32'(bus.mispred_cnt_o), 32'd0);
        modelReset();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            stepCycle();
            checkOutput("post_reset_cause", 32'(bus.jump_cause_o), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
